sram22_rw_port_ctrl: RTL and testbench

//  Request front-end that sits directly upstream of an sram22 single-port macro (ce/we/wmask/addr/din/dout).

---
 rtl/sram22_rw_port_ctrl_if.sv | 32 +++
 rtl/sram22_rw_port_ctrl.sv | 138 +++++++++++++
 tb/tb_sram22_rw_port_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram22_rw_port_ctrl_if.sv
// Request/response bundle between a client and the sram22 port controller.
// Handshake rule for both channels: a transfer happens at a rising clk edge
// where valid and ready are both high; the source holds valid and its payload
// stable until that edge, and ready may depend combinationally on the other
// channel (req_ready looks at rsp_ready).
interface sram22_rw_port_ctrl_if #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [WMASK_WIDTH-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_rdata;

    // Client side: issues requests, consumes responses.
    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram22_rw_port_ctrl.sv
// Front-end for an sram22 single-port macro. Converts a valid/ready request
// stream into macro pin activity, captures registered read data into a
// 2-entry response FIFO (giving the read path backpressure) and optionally
// zero-fills the whole array after reset before accepting traffic.
module sram22_rw_port_ctrl #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 4,
    parameter bit INIT_ZERO   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    sram22_rw_port_ctrl_if.slave   bus,
    output logic                   init_done,
    output logic                   sram_rstb,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout,
    output logic                   dbg_state
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t                RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST    = '1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

    // Response FIFO: two entries, pointer per side, explicit occupancy.
    logic [DATA_WIDTH-1:0]   fifo_mem [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              occ_q;
    logic                    inflight_q;

    logic                    run_ok;
    logic                    push;
    logic                    pop;
    logic                    fire;
    logic [2:0]              used;

    // Handshake and credit terms. A slot is owed to every buffered response
    // and to the read currently inside the macro; a pop in this cycle frees
    // one, which is what allows one read per cycle with rsp_ready held high.
    assign run_ok        = (state_q == ST_RUN) & ~rst;
    assign push          = inflight_q;
    assign bus.rsp_valid = (occ_q != 2'd0) & ~rst;
    assign pop           = bus.rsp_valid & bus.rsp_ready;
    assign used          = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign bus.req_ready = run_ok & (used < 3'd2);
    assign fire          = bus.req_valid & bus.req_ready;
    assign bus.rsp_rdata = fifo_mem[rd_ptr_q];
    assign sram_rstb     = ~rst;
    assign dbg_state     = state_q;

    // State and zero-fill counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and macro pin drive; everything is quiet while rst is high.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        init_done  = 1'b0;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (!rst) begin
            case (state_q)
                ST_INIT: begin
                    sram_ce    = 1'b1;
                    sram_we    = 1'b1;
                    sram_wmask = '1;
                    sram_addr  = cnt_q;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_done  = 1'b1;
                    sram_ce    = fire;
                    sram_we    = bus.req_we;
                    sram_wmask = bus.req_wmask;
                    sram_addr  = bus.req_addr;
                    sram_din   = bus.req_wdata;
                end
                default: begin
                    state_d = RESET_STATE;
                end
            endcase
        end
    end

    // Read tracking and FIFO bookkeeping; reset discards buffered and
    // in-flight read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            inflight_q <= fire & ~bus.req_we;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage: macro dout is valid the cycle after the read edge.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= sram_dout;
        end
    end

endmodule

// File: tb/tb_sram22_rw_port_ctrl.sv
module tb_sram22_rw_port_ctrl;
    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int LW    = DW / MW;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram22_rw_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) bus ();

    logic          init_done, sram_rstb, sram_ce, sram_we, dbg_state;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;

    sram22_rw_port_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .INIT_ZERO(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .init_done(init_done), .sram_rstb(sram_rstb), .sram_ce(sram_ce),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout), .dbg_state(dbg_state)
    );

    // ---------------- sram22 macro model ----------------
    logic [DW-1:0] macro_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) macro_mem[i] = $urandom;
        sram_dout = $urandom;
    end
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int l = 0; l < MW; l++)
                    if (sram_wmask[l]) macro_mem[sram_addr][l*LW +: LW] <= sram_din[l*LW +: LW];
            end else begin
                sram_dout <= macro_mem[sram_addr];
            end
        end
    end

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            pop_cyc[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_pops   = 0;
    int            cyc      = 0;
    logic [DW-1:0] last_pop;
    logic          last_fire;
    logic          rst_cmd  = 1'b1;
    logic          rr_cur   = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Reference behaviour of an accepted request: writes merge unmasked
    // lanes into the array, reads owe the current word as the next response.
    task automatic model_accept(input logic we, input logic [MW-1:0] m,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (we) begin
            for (int l = 0; l < MW; l++)
                if (m[l]) ref_mem[a][l*LW +: LW] = d[l*LW +: LW];
        end else begin
            exp_q.push_back(ref_mem[a]);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One cycle: inputs change at negedge, handshake is sampled 3 time units later.
    task automatic drive(input logic v, input logic we, input logic [MW-1:0] m,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
        @(negedge clk);
        rst           = rst_cmd;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_wmask = m;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = rr;
        #3;
        last_fire = v && bus.req_ready;
        if (last_fire) model_accept(we, m, a, d);
    endtask

    task automatic issue(input logic we, input logic [MW-1:0] m,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k;
        k = 0;
        do begin
            drive(1'b1, we, m, a, d, rr_cur);
            k++;
        end while (!last_fire && k < 50);
        if (!last_fire) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: request @%0h not accepted in 50 cycles", a);
        end
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, 1'b0, '0, '0, '0, rr);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            idle(1'b1);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    // ---------------- monitor ----------------
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data;
    always @(negedge clk) begin
        #3;
        if (hold_prev && bus.rsp_valid) check("rdata_hold", bus.rsp_rdata, hold_data);
        hold_prev = bus.rsp_valid && !bus.rsp_ready;
        hold_data = bus.rsp_rdata;
        if (bus.rsp_valid && bus.rsp_ready) begin
            n_pops++;
            pop_cyc.push_back(cyc);
            last_pop = bus.rsp_rdata;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got %0h, required no response", bus.rsp_rdata);
            end else begin
                check("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic          pend_v, pend_we;
        logic [MW-1:0] pend_m;
        logic [AW-1:0] pend_a;
        logic [DW-1:0] pend_d;
        logic          rr;
        int            c0, acc, pops0, k;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_wmask = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
        model_clear();

        // Reset values
        rst_cmd = 1'b1;
        repeat (3) idle(1'b1);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_init_done", init_done, 0);
        check("rst_sram_ce", sram_ce, 0);
        check("rst_sram_rstb", sram_rstb, 0);

        // Zero-fill sweep
        rst_cmd = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idle(1'b1);
            check("init_addr", sram_addr, i[AW-1:0]);
            check("init_pins", {sram_ce, sram_we, sram_wmask, init_done, bus.req_ready, sram_rstb},
                  {1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1});
            check("init_din", sram_din, 0);
        end
        idle(1'b1);
        check("init_done_rise", init_done, 1);
        check("run_req_ready", bus.req_ready, 1);

        // Read of a zero-filled word
        rr_cur = 1'b1;
        issue(1'b0, '0, 7'd5, '0);
        drain();
        check("zero_fill_rd5", last_pop, 32'h0);

        // Masked write merge
        issue(1'b1, 4'hF, 7'd3, 32'hDEADBEEF);
        issue(1'b1, 4'b0101, 7'd3, 32'h11223344);
        issue(1'b0, '0, 7'd3, '0);
        drain();
        check("mask_merge", last_pop, 32'hDE22BE44);

        // wmask=0 write changes nothing
        issue(1'b1, 4'hF, 7'd9, 32'hA5A5A5A5);
        issue(1'b1, 4'h0, 7'd9, 32'hFFFFFFFF);
        issue(1'b0, '0, 7'd9, '0);
        drain();
        check("mask_zero", last_pop, 32'hA5A5A5A5);

        // Back-to-back reads with rsp_ready held high
        for (int i = 0; i < 8; i++) issue(1'b1, 4'hF, i[AW-1:0], $urandom);
        drain();
        pop_cyc.delete();
        c0 = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, '0, i[AW-1:0], '0, 1'b1);
            check("b2b_fire", last_fire, 1);
            if (i == 0) c0 = cyc;
        end
        drain();
        check("b2b_count", pop_cyc.size(), 8);
        for (int j = 0; j < 8 && j < pop_cyc.size(); j++)
            check("b2b_latency", pop_cyc[j], c0 + 2 + j);

        // Backpressure: only two reads accepted while rsp_ready is low
        pops0 = n_pops;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, '0, acc[AW-1:0], '0, 1'b0);
            if (last_fire) acc++;
        end
        check("bp_accepted", acc, 2);
        check("bp_req_ready", bus.req_ready, 0);
        rr_cur = 1'b1;
        for (int i = acc; i < 6; i++) issue(1'b0, '0, i[AW-1:0], '0);
        drain();
        check("bp_pops", n_pops - pops0, 6);

        // Randomized traffic with random response backpressure
        pend_v = 1'b0; pend_we = 1'b0; pend_m = '0; pend_a = '0; pend_d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend_v) begin
                pend_v  = ($urandom_range(0, 3) != 0);
                pend_we = $urandom_range(0, 1) == 1;
                pend_m  = $urandom_range(0, 15);
                pend_a  = $urandom_range(0, 15);
                pend_d  = $urandom;
            end
            rr = ($urandom_range(0, 3) != 0);
            drive(pend_v, pend_we, pend_m, pend_a, pend_d, rr);
            if (last_fire) pend_v = 1'b0;
        end
        drain();

        // Reset with FIFO occupied and a read in flight
        issue(1'b1, 4'hF, 7'd20, 32'h12345678);
        issue(1'b1, 4'hF, 7'd21, 32'h9ABCDEF0);
        drive(1'b1, 1'b0, '0, 7'd20, '0, 1'b0);
        drive(1'b1, 1'b0, '0, 7'd21, '0, 1'b0);
        idle(1'b0);
        rst_cmd = 1'b1;
        idle(1'b0);
        rst_cmd = 1'b0;
        model_clear();
        idle(1'b1);
        check("rstmid_rsp_valid", bus.rsp_valid, 0);
        check("rstmid_init_restart", {sram_ce, sram_we, init_done}, {1'b1, 1'b1, 1'b0});
        check("rstmid_init_addr", sram_addr, 0);
        k = 0;
        while (!init_done && k < 200) begin
            idle(1'b1);
            k++;
        end
        check("rstmid_init_done", init_done, 1);
        issue(1'b0, '0, 7'd20, '0);
        issue(1'b0, '0, 7'd21, '0);
        drain();
        check("rstmid_rezero", last_pop, 32'h0);

        repeat (3) idle(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
